kbd_scan_decoder: RTL and testbench

KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

---
 rtl/kbd_scan_decoder.sv | 130 +++++++++++++
 tb/tb_kbd_scan_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_decoder.sv
// PS/2 scan-byte prefix decoder feeding a small event FIFO.
// Define KBD_REPEAT_FILTER_EN to drop typematic repeats of a held key.
module kbd_scan_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         code_valid,
    input  logic [7:0]                   code_data,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [9:0]                   evt_data,
    output logic [$clog2(FIFO_DEPTH):0]  evt_count,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_complete;
    logic [9:0]      w_evt;
    logic            w_push;
    logic            w_full;
    logic            w_wr;
    logic            w_rd;
    logic            w_drop;

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_evt       = {2'b00, code_data};
        if (code_valid) begin
            if (code_data == 8'hE0) begin
                w_state_nxt = EXT;
            end else if (code_data == 8'hF0) begin
                case (r_state)
                    IDLE:    w_state_nxt = BRK;
                    EXT:     w_state_nxt = EXT_BRK;
                    default: w_state_nxt = r_state;
                endcase
            end else begin
                w_complete  = 1'b1;
                w_state_nxt = IDLE;
                w_evt[9]    = (r_state == BRK) || (r_state == EXT_BRK);
                w_evt[8]    = (r_state == EXT) || (r_state == EXT_BRK);
            end
        end
    end

`ifdef KBD_REPEAT_FILTER_EN
    logic [8:0] r_last_make;
    logic       r_held;
    logic       w_match;
    logic       w_repeat;

    assign w_match  = (w_evt[8:0] == r_last_make);
    assign w_repeat = !w_evt[9] && r_held && w_match;
    assign w_push   = w_complete && !w_repeat;

    // Filter state tracks the key stream even if the FIFO drops the event
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_make <= '0;
            r_held      <= 1'b0;
        end else if (w_complete) begin
            if (!w_evt[9] && !w_repeat) begin
                r_last_make <= w_evt[8:0];
                r_held      <= 1'b1;
            end else if (w_evt[9] && w_match) begin
                r_held      <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_complete;
`endif

    assign evt_valid = (r_count != '0);
    assign w_full    = (r_count == FIFO_DEPTH[AW:0]);
    assign w_rd      = evt_valid && evt_ready;
    assign w_wr      = w_push && (!w_full || w_rd);
    assign w_drop    = w_push && w_full && !w_rd;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_evt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      r_overflow <= 1'b0;
        else if (w_drop)  r_overflow <= 1'b1;
        else if (ovf_clr) r_overflow <= 1'b0;
    end

    // Memory is not reset, so mask the head while empty
    assign evt_data  = evt_valid ? r_mem[r_rptr] : '0;
    assign evt_count = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed self-checking bench for kbd_scan_decoder (FIFO_DEPTH=8).
// Expectations follow KBD_REPEAT_FILTER_EN when it is defined.
module tb_kbd_scan_decoder;

    logic       clk;
    logic       resetn;
    logic       code_valid;
    logic [7:0] code_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [9:0] evt_data;
    logic [3:0] evt_count;
    logic       overflow;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;

    kbd_scan_decoder #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .code_valid (code_valid),
        .code_data  (code_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_count  (evt_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        code_valid = 1'b1;
        code_data  = b;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code_data  = 8'h00;
    endtask

    task automatic pop_one();
        @(negedge clk);
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        code_valid = 1'b0;
        code_data  = 8'h00;
        evt_ready  = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", evt_valid);
        end
        checks++;
        if (evt_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_data: got %h want 000", evt_data);
        end
        checks++;
        if (evt_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", evt_count);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", overflow);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== 10'h01C) begin
            errors++;
            $display("FAIL make_1c: got v=%b d=%h want v=1 d=01c",
                     evt_valid, evt_data);
        end
        pop_one();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty: got v=%b want 0", evt_valid);
        end
        send_byte(8'hF0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL f0_no_evt: got v=%b want 0", evt_valid);
        end
        send_byte(8'h1C);
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== 10'h21C) begin
            errors++;
            $display("FAIL break_1c: got v=%b d=%h want v=1 d=21c",
                     evt_valid, evt_data);
        end
        pop_one();
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if (evt_count !== 4'd1 || evt_data !== 10'h375) begin
            errors++;
            $display("FAIL ext_brk: got n=%0d d=%h want n=1 d=375",
                     evt_count, evt_data);
        end
        pop_one();
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h6B);
        checks++;
        if (evt_count !== 4'd1 || evt_data !== 10'h16B) begin
            errors++;
            $display("FAIL e0_discard: got n=%0d d=%h want n=1 d=16b",
                     evt_count, evt_data);
        end
        pop_one();
        checks++;
        if (evt_count !== 4'd0) begin
            errors++;
            $display("FAIL ext_drain: got n=%0d want 0", evt_count);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp;
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
        checks++;
        if (evt_count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: got n=%0d o=%b want n=8 o=1",
                     evt_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            exp = 10'h010 + 10'(i);
            checks++;
            if (evt_data !== exp) begin
                errors++;
                $display("FAIL ovf_drain%0d: got %h want %h",
                         i, evt_data, exp);
            end
            pop_one();
        end
        checks++;
        if (evt_count !== 4'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got n=%0d o=%b want n=0 o=1",
                     evt_count, overflow);
        end
        pulse_clr();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b want 0", overflow);
        end
        for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i));
        @(negedge clk);
        code_valid = 1'b1;
        code_data  = 8'h38;
        ovf_clr    = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        ovf_clr    = 1'b0;
        checks++;
        if (overflow !== 1'b1 || evt_count !== 4'd8 ||
            evt_data !== 10'h030) begin
            errors++;
            $display("FAIL set_wins: got o=%b n=%0d d=%h want o=1 n=8 d=030",
                     overflow, evt_count, evt_data);
        end
        for (int i = 0; i < 8; i++) pop_one();
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
        @(negedge clk);
        code_valid = 1'b1;
        code_data  = 8'h2A;
        evt_ready  = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        evt_ready  = 1'b0;
        checks++;
        if (evt_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: got n=%0d o=%b want n=8 o=0",
                     evt_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 10'h021 + 10'(i) : 10'h02A;
            checks++;
            if (evt_data !== exp) begin
                errors++;
                $display("FAIL b2b_drain%0d: got %h want %h",
                         i, evt_data, exp);
            end
            pop_one();
        end
    endtask

    task automatic test_repeat();
        logic [9:0] exp [5];
        int         n;
`ifdef KBD_REPEAT_FILTER_EN
        n      = 3;
        exp[0] = 10'h01C;
        exp[1] = 10'h21C;
        exp[2] = 10'h01C;
        exp[3] = 10'h000;
        exp[4] = 10'h000;
`else
        n      = 5;
        exp[0] = 10'h01C;
        exp[1] = 10'h01C;
        exp[2] = 10'h01C;
        exp[3] = 10'h21C;
        exp[4] = 10'h01C;
`endif
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        checks++;
        if (evt_count !== 4'(n) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rpt_count: got n=%0d o=%b want n=%0d o=0",
                     evt_count, overflow, n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (evt_data !== exp[i]) begin
                errors++;
                $display("FAIL rpt_drain%0d: got %h want %h",
                         i, evt_data, exp[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h44);
        send_byte(8'hE0);
        send_byte(8'hF0);
        @(negedge clk);
        resetn = 1'b0;
        #2;
        checks++;
        if (evt_count !== 4'd0 || evt_valid !== 1'b0 ||
            evt_data !== 10'h000) begin
            errors++;
            $display("FAIL async_rst: got n=%0d v=%b d=%h want n=0 v=0 d=000",
                     evt_count, evt_valid, evt_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'h1C);
        checks++;
        if (evt_count !== 4'd1 || evt_data !== 10'h01C) begin
            errors++;
            $display("FAIL rst_prefix: got n=%0d d=%h want n=1 d=01c",
                     evt_count, evt_data);
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_overflow();
        test_back_to_back();
        test_repeat();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
